param_register_block: RTL

Parametrised successor of the CPU register file. DEPTH x DATA_WIDTH array with two combinational read ports and one clocked write port. Adds:
- word, byte and halfword write modes
- same-cycle write-to-read forwarding
- a hardwired zero register
- a sequenced bulk-clear engine
Sits between decode (register addresses) and the ALU/writeback stage of the datapath.

---
 rtl/param_register_block.sv | 101 ++++++++++
 1 files changed

// File: rtl/param_register_block.sv
// Parametrised register file: two combinational read ports, one clocked
// write port with word/byte/halfword modes, same-cycle write-to-read
// forwarding, optional hardwired zero register and a sequenced bulk clear.
module param_register_block #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter bit ZERO_REG_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  regWrite,
  input  logic [1:0]            write_mode,
  input  logic                  clear_req,
  output logic                  busy,
  output logic                  write_dropped
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {IDLE, CLEAR} state_t;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  zero_wr;
  logic                  wr_acc;
  logic [DATA_WIDTH-1:0] merged;

  assign zero_wr = ZERO_REG_EN && (write_reg == '0);
  assign wr_acc  = regWrite && (state == IDLE) && !zero_wr;

  // New register value: low field replaced per mode, upper bits kept
  always_comb begin
    merged = regs[write_reg];
    case (write_mode)
      2'b01:   merged[7:0]  = write_data[7:0];
      2'b10:   merged[15:0] = write_data[15:0];
      default: merged       = write_data;
    endcase
  end

  // Read port 1: array, forwarded write, then zero-register override
  always_comb begin
    read_data1 = regs[read_reg1];
    if (wr_acc && read_reg1 == write_reg) read_data1 = merged;
    if (ZERO_REG_EN && read_reg1 == '0)   read_data1 = '0;
  end

  // Read port 2: same rules, forwarded independently of port 1
  always_comb begin
    read_data2 = regs[read_reg2];
    if (wr_acc && read_reg2 == write_reg) read_data2 = merged;
    if (ZERO_REG_EN && read_reg2 == '0)   read_data2 = '0;
  end

  // Register array: accepted writes in IDLE, one entry zeroed per CLEAR cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (wr_acc)          regs[write_reg] <= merged;
      if (state == CLEAR)  regs[cnt]       <= '0;
    end
  end

  // Clear sequencer with registered busy / write_dropped outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      busy          <= 1'b0;
      write_dropped <= 1'b0;
    end else begin
      write_dropped <= regWrite && (state == CLEAR);
      case (state)
        IDLE: begin
          if (clear_req) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          if (&cnt) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
